// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: round-robin share of one block_ram TileLink-A port between
// an instruction-fetch requester (port 0) and a load/store requester (port 1).
// The RAM answers 1 cycle after a_valid; the response is presented to the
// owning requester and buffered if that requester stalls.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req0_tla / req1_tla     requester A channel (packed, layout below)
//   req0_d_ready/req1_d_ready  requester accepts its D response
//   req0_ready / req1_ready grant to the requester this cycle (combinational)
//   req0_tld / req1_tld     D response to the requester (packed, layout below)
//   ram_tla                 A channel towards block_ram
//   ram_rdata               block_ram read/merged word, valid 1 cycle after a_valid
//
// A layout [78:0]: a_valid[78] a_opcode[77:75] a_size[74:72] a_source[71:68]
//                  a_address[67:36] a_mask[35:32] a_data[31:0]
// D layout [44:0]: d_valid[44] d_opcode[43:41] d_size[40:38] d_source[37:34]
//                  d_sink[33] d_error[32] d_data[31:0]
module block_ram_arbiter #(
    parameter int unsigned ADDR_BITS = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned TLA_W = 79,
    localparam int unsigned TLD_W = 45
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [TLA_W-1:0] req0_tla,
    input  logic             req0_d_ready,
    output logic             req0_ready,
    output logic [TLD_W-1:0] req0_tld,
    input  logic [TLA_W-1:0] req1_tla,
    input  logic             req1_d_ready,
    output logic             req1_ready,
    output logic [TLD_W-1:0] req1_tld,
    output logic [TLA_W-1:0] ram_tla,
    input  logic [31:0]      ram_rdata
);

    localparam int unsigned A_VALID    = 78;
    localparam int unsigned A_OPC_LSB  = 75;
    localparam int unsigned A_SIZE_LSB = 72;
    localparam int unsigned A_SRC_LSB  = 68;
    localparam int unsigned A_ADDR_LSB = 36;
    localparam int unsigned TAG_BITS   = 32 - ADDR_BITS;
    localparam logic [2:0]  OP_GET     = 3'd4;
    localparam logic [2:0]  OP_ACK     = 3'd0;
    localparam logic [2:0]  OP_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic        in_range_q;
    logic [2:0]  opcode_q;
    logic [2:0]  size_q;
    logic [3:0]  source_q;
    logic [31:0] hold_data;

    logic             valid0;
    logic             valid1;
    logic             owner_ready;
    logic             resp_active;
    logic             accept;
    logic             grant;
    logic             win1;
    logic             win_in_range;
    logic [TLA_W-1:0] win_tla;
    logic [31:0]      resp_data;
    logic [TLD_W-1:0] resp_tld;

    // Grant window, round-robin pick and response formatting.
    always_comb begin
        valid0       = req0_tla[A_VALID];
        valid1       = req1_tla[A_VALID];
        owner_ready  = owner ? req1_d_ready : req0_d_ready;
        resp_active  = (state != IDLE);
        accept       = resp_active && owner_ready;
        // On a tie the port that did not win last time gets it.
        win1         = valid1 && (!valid0 || !last_grant);
        grant        = !reset && (state == IDLE || accept) && (valid0 || valid1);
        win_tla      = win1 ? req1_tla : req0_tla;
        win_in_range = (win_tla[A_ADDR_LSB + ADDR_BITS +: TAG_BITS] == BASE_ADDR[31:ADDR_BITS]);

        if (state == HOLD) begin
            resp_data = hold_data;
        end else begin
            resp_data = in_range_q ? ram_rdata : 32'h0;
        end

        resp_tld = {1'b1,
                    (opcode_q == OP_GET) ? OP_ACK_DATA : OP_ACK,
                    size_q,
                    source_q,
                    1'b0,
                    !in_range_q,
                    resp_data};
    end

    // Outputs are forced low while reset is held, even if a request is pending.
    always_comb begin
        req0_ready = grant && !win1;
        req1_ready = grant && win1;
        // Out-of-range requests never reach the RAM, so a Put cannot alias.
        ram_tla    = (grant && win_in_range) ? win_tla : '0;
        req0_tld   = (!reset && resp_active && !owner) ? resp_tld : '0;
        req1_tld   = (!reset && resp_active &&  owner) ? resp_tld : '0;
    end

    // Request latch, response hold buffer and state progression.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            in_range_q <= 1'b0;
            opcode_q   <= 3'd0;
            size_q     <= 3'd0;
            source_q   <= 4'd0;
            hold_data  <= 32'h0;
        end else if (grant) begin
            state      <= RESP;
            owner      <= win1;
            last_grant <= win1;
            in_range_q <= win_in_range;
            opcode_q   <= win_tla[A_OPC_LSB  +: 3];
            size_q     <= win_tla[A_SIZE_LSB +: 3];
            source_q   <= win_tla[A_SRC_LSB  +: 4];
        end else if (state == RESP && !owner_ready) begin
            // RAM data is only valid this cycle; keep it for the stalled owner.
            state      <= HOLD;
            hold_data  <= resp_data;
        end else if (accept) begin
            state      <= IDLE;
        end
    end

endmodule
